// File: rtl/chess_pkg.sv
// Shared constants, direction enum and move-word packing
// for the 2x2 move-generator tile.
package chess_pkg;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  localparam logic [4:0] EMPTY  = 5'b00000;
  localparam logic [4:0] KNIGHT = 5'b00001;
  localparam logic [4:0] PAWN   = 5'b00010;
  localparam logic [4:0] KING   = 5'b00100;
  localparam logic [4:0] BISHOP = 5'b01000;
  localparam logic [4:0] ROOK   = 5'b10000;
  localparam logic [4:0] QUEEN  = 5'b11000;

  typedef enum logic [2:0] {
    U, D, L, R, UL, UR, DL, DR
  } dir_e;

  function automatic logic [31:0] pack_move(
    input logic [5:0] tgt,
    input logic [5:0] tgt_pos,
    input logic [5:0] src,
    input logic [5:0] src_pos
  );
    return {2'b00, tgt, 2'b00, tgt_pos,
            2'b00, src, 2'b00, src_pos};
  endfunction

endpackage

// File: rtl/chess_board_2x2_dir_move_eval.sv
// Combinational evaluation of one move direction.
// Ports: src/tgt codes and positions, dir, color -> move word.
module dir_move_eval
  import chess_pkg::*;
(
  input  logic [5:0]  src_i,
  input  logic [5:0]  tgt_i,
  input  logic [5:0]  src_pos_i,
  input  logic [5:0]  tgt_pos_i,
  input  dir_e        dir_i,
  input  logic        color_i,
  output logic [31:0] move_o
);

  logic [4:0] typ;
  logic       own, tgt_occ, enemy;
  logic       orth, fwd_o, fwd_d;
  logic       is_pawn, is_king, perm;

  always_comb begin
    typ     = src_i[4:0];
    own     = (typ != EMPTY) && (src_i[5] == color_i);
    tgt_occ = (tgt_i[4:0] != EMPTY);
    enemy   = tgt_occ && (tgt_i[5] != color_i);
    is_pawn = (typ == PAWN);
    is_king = (typ == KING);
    orth    = (dir_i == U) || (dir_i == D) ||
              (dir_i == L) || (dir_i == R);
    // forward is toward the opponent's side
    fwd_o   = color_i ? (dir_i == U) : (dir_i == D);
    fwd_d   = color_i ? (dir_i == UL || dir_i == UR)
                      : (dir_i == DL || dir_i == DR);
    if (orth)
      perm = typ[4] || is_king ||
             (is_pawn && fwd_o && !tgt_occ);
    else
      perm = typ[3] || is_king ||
             (is_pawn && fwd_d && enemy);
    move_o = 32'h0;
    if (own && (!tgt_occ || enemy) && perm)
      move_o = pack_move(tgt_i, tgt_pos_i,
                         src_i, src_pos_i);
  end

endmodule

// File: rtl/chess_board_2x2.sv
// 2x2 move-generator tile: 12 direction evaluators plus
// one registered output bank (async active-low clear).
module chess_board_2x2
  import chess_pkg::*;
#(
  parameter logic [5:0] SQ0_POS = 6'd0,
  parameter logic [5:0] SQ1_POS = 6'd1,
  parameter logic [5:0] SQ2_POS = 6'd2,
  parameter logic [5:0] SQ3_POS = 6'd3
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        engineColor,
  input  logic        enable,
  input  logic [5:0]  pieceReg0,
  input  logic [5:0]  pieceReg1,
  input  logic [5:0]  pieceReg2,
  input  logic [5:0]  pieceReg3,
  output logic [31:0] U_move_out0,
  output logic [31:0] L_move_out0,
  output logic [31:0] UL_move_out0,
  output logic [31:0] U_move_out1,
  output logic [31:0] R_move_out1,
  output logic [31:0] UR_move_out1,
  output logic [31:0] D_move_out2,
  output logic [31:0] L_move_out2,
  output logic [31:0] DL_move_out2,
  output logic [31:0] D_move_out3,
  output logic [31:0] R_move_out3,
  output logic [31:0] DR_move_out3
);

  localparam int SRC_TBL [12] =
    '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  localparam int TGT_TBL [12] =
    '{2, 1, 3, 3, 0, 2, 0, 3, 1, 1, 2, 0};
  localparam dir_e DIR_TBL [12] =
    '{U, L, UL, U, R, UR, D, L, DL, D, R, DR};

  logic [5:0]  sq  [4];
  logic [5:0]  pos [4];
  logic [31:0] move_d [12];
  logic [31:0] move_q [12];

  assign sq[0]  = pieceReg0;
  assign sq[1]  = pieceReg1;
  assign sq[2]  = pieceReg2;
  assign sq[3]  = pieceReg3;
  assign pos[0] = SQ0_POS;
  assign pos[1] = SQ1_POS;
  assign pos[2] = SQ2_POS;
  assign pos[3] = SQ3_POS;

  for (genvar k = 0; k < 12; k++) begin : g_eval
    dir_move_eval u_eval (
      .src_i     (sq[SRC_TBL[k]]),
      .tgt_i     (sq[TGT_TBL[k]]),
      .src_pos_i (pos[SRC_TBL[k]]),
      .tgt_pos_i (pos[TGT_TBL[k]]),
      .dir_i     (DIR_TBL[k]),
      .color_i   (engineColor),
      .move_o    (move_d[k])
    );
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int k = 0; k < 12; k++)
        move_q[k] <= 32'h0;
    end else if (enable) begin
      for (int k = 0; k < 12; k++)
        move_q[k] <= move_d[k];
    end
  end

  assign U_move_out0  = move_q[0];
  assign L_move_out0  = move_q[1];
  assign UL_move_out0 = move_q[2];
  assign U_move_out1  = move_q[3];
  assign R_move_out1  = move_q[4];
  assign UR_move_out1 = move_q[5];
  assign D_move_out2  = move_q[6];
  assign L_move_out2  = move_q[7];
  assign DL_move_out2 = move_q[8];
  assign D_move_out3  = move_q[9];
  assign R_move_out3  = move_q[10];
  assign DR_move_out3 = move_q[11];

endmodule

// File: tb/tb_chess_board_2x2.sv
// Self-checking bench for chess_board_2x2: geometric
// reference model plus hand-computed literal checks.
module tb_chess_board_2x2;

  logic        clk = 0;
  logic        clear = 0;
  logic        engineColor = 1;
  logic        enable = 0;
  logic [5:0]  b [4];
  logic [31:0] o [12];
  logic [31:0] exp_q [12];
  logic        cmp_en = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  chess_board_2x2 dut (
    .clk(clk), .clear(clear),
    .engineColor(engineColor), .enable(enable),
    .pieceReg0(b[0]), .pieceReg1(b[1]),
    .pieceReg2(b[2]), .pieceReg3(b[3]),
    .U_move_out0(o[0]), .L_move_out0(o[1]),
    .UL_move_out0(o[2]), .U_move_out1(o[3]),
    .R_move_out1(o[4]), .UR_move_out1(o[5]),
    .D_move_out2(o[6]), .L_move_out2(o[7]),
    .DL_move_out2(o[8]), .D_move_out3(o[9]),
    .R_move_out3(o[10]), .DR_move_out3(o[11])
  );

  // output k: source square and (drow, dcol) step
  int src_of [12] = '{0,0,0,1,1,1,2,2,2,3,3,3};
  int dr_of  [12] = '{1,0,1, 1,0,1, -1,0,-1, -1,0,-1};
  int dc_of  [12] = '{0,-1,-1, 0,1,1, 0,-1,-1, 0,1,1};

  function automatic int row_of(int s);
    return (s >= 2) ? 1 : 0;
  endfunction
  function automatic int col_of(int s);
    return (s % 2 == 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] model(int k,
      logic [5:0] p, logic [5:0] q0, logic [5:0] q1,
      logic [5:0] q2, logic [5:0] q3, logic c);
    logic [5:0] bd [4];
    int s, t, dr, dc, fwd;
    logic [5:0] pc, tc;
    logic emp, en, ok;
    bd[0] = q0; bd[1] = q1; bd[2] = q2; bd[3] = q3;
    s = src_of[k]; dr = dr_of[k]; dc = dc_of[k];
    t = -1;
    for (int i = 0; i < 4; i++)
      if (row_of(i) == row_of(s) + dr &&
          col_of(i) == col_of(s) + dc) t = i;
    pc = p; tc = bd[t];
    if (pc[4:0] == 0 || pc[5] != c) return 0;
    emp = (tc[4:0] == 0);
    en  = !emp && tc[5] != c;
    if (!emp && !en) return 0;
    fwd = c ? 1 : -1;
    ok = 0;
    if (pc[4:0] == 5'b00100) ok = 1;
    else if (pc[4:0] == 5'b00010)
      ok = (dr == fwd) &&
           ((dc == 0) ? emp : en);
    else if (dr != 0 && dc != 0) ok = pc[3];
    else ok = pc[4];
    if (!ok) return 0;
    return {2'b0, tc, 2'b0, 6'(t),
            2'b0, pc, 2'b0, 6'(s)};
  endfunction

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int k = 0; k < 12; k++) exp_q[k] <= 0;
    end else if (enable) begin
      for (int k = 0; k < 12; k++)
        exp_q[k] <= model(k, b[src_of[k]], b[0], b[1],
                          b[2], b[3], engineColor);
    end
  end

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en)
      for (int k = 0; k < 12; k++)
        chk($sformatf("model_out%0d", k), o[k], exp_q[k]);
  end

  task automatic setb(logic [5:0] s0, logic [5:0] s1,
                      logic [5:0] s2, logic [5:0] s3,
                      logic c);
    b[0] = s0; b[1] = s1; b[2] = s2; b[3] = s3;
    engineColor = c;
  endtask

  task automatic wait2();
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    setb(0, 0, 0, 0, 1);
    #3;
    for (int k = 0; k < 12; k++)
      chk($sformatf("reset_out%0d", k), o[k], 32'h0);
    @(negedge clk);
    clear = 1; enable = 1; cmp_en = 1;

    setb(6'b111000, 6'b100010, 6'b011000, 6'b010000, 1);
    wait2();
    chk("mix_U0",  o[0], 32'h18023800);
    chk("mix_UL0", o[2], 32'h10033800);
    chk("mix_UR1", o[5], 32'h18022201);
    chk("mix_L0",  o[1], 32'h0);
    chk("mix_U1",  o[3], 32'h0);
    chk("mix_R1",  o[4], 32'h0);
    for (int k = 6; k < 12; k++)
      chk($sformatf("mix_sq23_%0d", k), o[k], 32'h0);

    engineColor = 0;
    wait2();
    chk("blk_D2",  o[6],  32'h38001802);
    chk("blk_DL2", o[8],  32'h22011802);
    chk("blk_D3",  o[9],  32'h22011003);
    chk("blk_DR3", o[11], 32'h0);
    chk("blk_L2",  o[7],  32'h0);
    chk("blk_R3",  o[10], 32'h0);

    setb(0, 6'b100010, 0, 0, 1);
    wait2();
    chk("push_U1",  o[3], 32'h00032201);
    chk("push_UR1", o[5], 32'h0);
    chk("push_R1",  o[4], 32'h0);

    setb(6'b100001, 0, 0, 0, 1);
    wait2();
    for (int k = 0; k < 12; k++)
      chk($sformatf("knight_%0d", k), o[k], 32'h0);

    setb(6'b100100, 0, 0, 0, 1);
    wait2();
    chk("king_U0",  o[0], 32'h00022400);
    chk("king_L0",  o[1], 32'h00012400);
    chk("king_UL0", o[2], 32'h00032400);

    // black pawn: forward diagonal capture only
    setb(6'b100100, 0, 6'b000010, 0, 0);
    wait2();
    chk("bpawn_D2",  o[6], 32'h0);
    chk("bpawn_DL2", o[8], 32'h0);

    setb(6'b111000, 6'b100010, 6'b011000, 6'b010000, 1);
    wait2();
    #2 clear = 0;
    #1;
    chk("clr_U0",  o[0], 32'h0);
    chk("clr_UR1", o[5], 32'h0);
    @(negedge clk);
    clear = 1; enable = 0;
    setb(6'b100100, 0, 0, 0, 1);
    wait2();
    chk("hold_U0", o[0], 32'h0);
    chk("hold_L0", o[1], 32'h0);
    enable = 1;
    wait2();
    chk("en_U0", o[0], 32'h00022400);
    chk("en_L0", o[1], 32'h00012400);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/chess_board_2x2.md
# chess_board_2x2

2x2 chess-board move-generator tile. It holds no board state. Each cycle it evaluates the four input square codes and registers one candidate-move word per outward-adjacent direction of each square: 12 words, 3 per square. It is the leaf evaluation tile of the engine's move generator, and larger boards are built from these tiles.

## Interface
Parameters:
- `SQ0_POS`, default 6'd0: board index of square 0.
- `SQ1_POS`, default 6'd1: board index of square 1.
- `SQ2_POS`, default 6'd2: board index of square 2.
- `SQ3_POS`, default 6'd3: board index of square 3.

Ports:
- `clk`  in  1  the single clock; all outputs are registered on the rising edge.
- `clear`  in  1  reset, asynchronous, active-low.
- `engineColor`  in  1  side to move: 1 = WHITE, 0 = BLACK.
- `enable`  in  1  capture enable for the output registers.
- `pieceReg0` .. `pieceReg3`  in  6 each  square codes, formatted {color, type[4:0]}.
- `U_move_out0`, `L_move_out0`, `UL_move_out0`  out  32 each  moves from square 0.
- `U_move_out1`, `R_move_out1`, `UR_move_out1`  out  32 each  moves from square 1.
- `D_move_out2`, `L_move_out2`, `DL_move_out2`  out  32 each  moves from square 2.
- `D_move_out3`, `R_move_out3`, `DR_move_out3`  out  32 each  moves from square 3.

## Operation
Piece type codes (5 bits):
- PAWN 00010, KNIGHT 00001, KING 00100.
- BISHOP 01000, ROOK 10000, QUEEN 11000.

Square codes:
- An empty square is 6'b000000.
- A square is occupied when type != 0.

Geometry (U is white's forward direction):
- Top row, left to right: square 3, square 2.
- Bottom row, left to right: square 1, square 0.

Direction targets:
- Square 0: U -> 2, L -> 1, UL -> 3.
- Square 1: U -> 3, R -> 0, UR -> 2.
- Square 2: D -> 0, L -> 3, DL -> 1.
- Square 3: D -> 1, R -> 2, DR -> 0.

A move from source s to target t is valid only when all of the following hold:
- s is occupied and its color bit equals `engineColor`.
- t is empty, or t is occupied with the opposite color.
- The piece type permits the direction:
  - Orthogonal (U/D/L/R): type[4] set (rook, queen) or KING.
  - Diagonal: type[3] set (bishop, queen) or KING.
  - PAWN orthogonal: only the forward direction (U for white, D for black), and only when t is empty.
  - PAWN diagonal: only a forward diagonal, and only when t holds an enemy piece.
  - KNIGHT: never valid inside a 2x2 tile.

Move word for a valid move:
- [29:24] = target square code (captured piece; 000000 if the target is empty).
- [21:16] = target SQn_POS.
- [13:8] = source square code.
- [5:0] = source SQn_POS.
- Bits [31:30], [23:22], [15:14] and [7:6] are 0.

An invalid move produces 32'h0.

## Timing
- `clear` low forces all 12 outputs to 32'h0 immediately, independent of `clk`, and holds them there while low.
- When `clear` is high and `enable` is high, every output loads its combinational result at the rising edge. Latency is one cycle from input change to output.
- When `enable` is low, outputs hold their value.
- `pieceReg*` and `engineColor` are sampled only at the clock edge; changes between edges have no effect.
- `clear` deasserting coincident with an edge: that edge loads normally only if `clear` meets recovery time. Otherwise outputs stay 0 until the next edge.
- Each output depends only on its own source and target squares. There is no cross-direction interaction.

## Structure
Shared package `chess_pkg`:
- Color constants: WHITE, BLACK.
- Piece type constants: PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING, EMPTY.
- A move-word packing function.
- Direction enumeration: U, D, L, R, UL, UR, DL, DR.

Sub-module `dir_move_eval`:
- Combinational.
- Inputs: source code, target code, source position, target position, direction, `engineColor`.
- Output: 32-bit move word.
- Instantiated 12 times, with one register bank at the top level.

## Test plan
- **Mixed position:**
  - Stimulus: `clear`=1, `enable`=1, WHITE to move; sq0 = white queen 111000, sq1 = white pawn 100010, sq2 = black queen 011000, sq3 = black rook 010000. Check after 2 edges.
  - `U_move_out0`: captured 011000, final 2, piece 111000, initial 0.
  - `UL_move_out0`: captured 010000, final 3, piece 111000, initial 0.
  - `UR_move_out1`: captured 011000, final 2, piece 100010, initial 1.
  - `L_move_out0`, `U_move_out1`, `R_move_out1`: 0 (own piece or blocked pawn).
  - All square-2 and square-3 outputs: 0 (wrong color).
- **Same board, BLACK to move:**
  - `D_move_out2`: captured 111000, final 0, piece 011000, initial 2.
  - `DL_move_out2`: captured 100010, final 1, piece 011000, initial 2.
  - `D_move_out3`: captured 100010, final 1, piece 010000, initial 3.
  - `DR_move_out3`: 0 (a rook cannot move diagonally).
  - `L_move_out2`, `R_move_out3`: 0 (own piece).
- **Pawn push:** white pawn on sq1, others empty -> `U_move_out1` = final 3, captured 0; `UR_move_out1` = 0; `R_move_out1` = 0.
- **Knight and king:**
  - White knight on sq0, others empty -> all 12 outputs 0.
  - White king on sq0, others empty -> all three square-0 outputs valid, each with captured 0.
- **Reset and enable:**
  - Assert `clear`=0 mid-run -> outputs 0 with no clock edge.
  - Release `clear`, drop `enable`, change the pieces -> outputs stay 0 until `enable` returns high.
